// File: rtl/cp0_unit.sv
// CP0 register block: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// Latency: writes and events land on the next rising edge; reads are combinational with write forwarding.
// Backpressure: none; exception > ERET > MTC0, and Count, timer and IP sampling run every cycle.
module cp0_unit #(
  parameter int          HW_INT_N     = 6,
  parameter int          COUNT_DIV    = 1,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_0000,
  parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [4:0]          raddr_i,
  input  logic [31:0]         data_i,
  input  logic [HW_INT_N-1:0] int_i,
  input  logic                excp_valid_i,
  input  logic [4:0]          excp_code_i,
  input  logic [31:0]         excp_pc_i,
  input  logic                excp_in_delay_i,
  input  logic                eret_i,
  output logic [31:0]         data_o,
  output logic [31:0]         count_o,
  output logic [31:0]         compare_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic [31:0]         config_o,
  output logic [31:0]         prid_o,
  output logic                timer_int_o,
  output logic                int_pending_o
);

  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  localparam logic [4:0]  REG_PRID    = 5'd15;
  localparam logic [4:0]  REG_CONFIG  = 5'd16;
  // Software-writable Cause bits: IV, WP, IP[1:0]
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;
  localparam int          PW          = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic [31:0]   status_q, status_d;
  logic [31:0]   cause_q, cause_d;
  logic [31:0]   epc_q, epc_d;
  logic          timer_q, timer_d;
  logic          wr_ok;
  logic          exl;
  logic [31:0]   cause_wr;
  logic [5:0]    ip_hw;
  logic [31:0]   rd_val;

  // MTC0 is dropped entirely whenever an exception or ERET commits
  assign wr_ok    = we_i & ~excp_valid_i & ~eret_i;
  assign exl      = status_q[1];
  assign cause_wr = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

  // Next-state for every register: events, MTC0, prescaled Count, timer and IP sampling
  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    timer_d   = timer_q;
    ip_hw     = '0;

    if (presc_q == PW'(COUNT_DIV - 1)) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if ((compare_q != 32'd0) && (count_q == compare_q)) timer_d = 1'b1;

    if (wr_ok) begin
      case (waddr_i)
        REG_COUNT: begin
          count_d = data_i;
          presc_d = '0;
        end
        REG_COMPARE: begin
          compare_d = data_i;
          timer_d   = 1'b0;
        end
        REG_STATUS: status_d = data_i;
        REG_CAUSE:  cause_d  = cause_wr;
        REG_EPC:    epc_d    = data_i;
        default: ;
      endcase
    end

    if (excp_valid_i) begin
      cause_d[6:2] = excp_code_i;
      if (!exl) begin
        epc_d       = excp_in_delay_i ? (excp_pc_i - 32'd4) : excp_pc_i;
        cause_d[31] = excp_in_delay_i;
        status_d[1] = 1'b1;
      end
    end else if (eret_i) begin
      status_d[1] = 1'b0;
    end

    for (int i = 0; i < HW_INT_N; i++) ip_hw[i] = int_i[i];
    cause_d[15:10] = ip_hw;
    cause_d[15]    = ip_hw[5] | timer_d;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= STATUS_RESET;
      cause_q   <= '0;
      epc_q     <= '0;
      timer_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  // Read mux with same-cycle forwarding of an accepted MTC0 to the read address
  always_comb begin
    rd_val = 32'd0;
    case (raddr_i)
      REG_COUNT:   rd_val = count_q;
      REG_COMPARE: rd_val = compare_q;
      REG_STATUS:  rd_val = status_q;
      REG_CAUSE:   rd_val = cause_q;
      REG_EPC:     rd_val = epc_q;
      REG_PRID:    rd_val = PRID_VALUE;
      REG_CONFIG:  rd_val = CONFIG_VALUE;
      default:     rd_val = 32'd0;
    endcase
    if (wr_ok && (waddr_i == raddr_i)) begin
      case (waddr_i)
        REG_COUNT, REG_COMPARE, REG_STATUS, REG_EPC: rd_val = data_i;
        REG_CAUSE: rd_val = cause_wr;
        default: ;
      endcase
    end
    data_o = rst ? rd_val : 32'd0;
  end

  assign count_o       = count_q;
  assign compare_o     = compare_q;
  assign status_o      = status_q;
  assign cause_o       = cause_q;
  assign epc_o         = epc_q;
  assign config_o      = CONFIG_VALUE;
  assign prid_o        = PRID_VALUE;
  assign timer_int_o   = timer_q;
  assign int_pending_o = status_q[0] & ~status_q[1] & |(cause_q[15:8] & status_q[15:8]);

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic        excp_valid_i;
  logic [4:0]  excp_code_i;
  logic [31:0] excp_pc_i;
  logic        excp_in_delay_i;
  logic        eret_i;

  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o, int_pending_o;
  logic [31:0] d4_data_o, d4_count_o, d4_compare_o, d4_status_o, d4_cause_o, d4_epc_o, d4_config_o, d4_prid_o;
  logic        d4_timer_int_o, d4_int_pending_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cp0_unit #(.HW_INT_N(6), .COUNT_DIV(1)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i), .data_i(data_i),
    .int_i(int_i), .excp_valid_i(excp_valid_i), .excp_code_i(excp_code_i), .excp_pc_i(excp_pc_i),
    .excp_in_delay_i(excp_in_delay_i), .eret_i(eret_i), .data_o(data_o), .count_o(count_o),
    .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .config_o(config_o), .prid_o(prid_o), .timer_int_o(timer_int_o), .int_pending_o(int_pending_o)
  );

  cp0_unit #(.HW_INT_N(6), .COUNT_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i), .data_i(data_i),
    .int_i(int_i), .excp_valid_i(excp_valid_i), .excp_code_i(excp_code_i), .excp_pc_i(excp_pc_i),
    .excp_in_delay_i(excp_in_delay_i), .eret_i(eret_i), .data_o(d4_data_o), .count_o(d4_count_o),
    .compare_o(d4_compare_o), .status_o(d4_status_o), .cause_o(d4_cause_o), .epc_o(d4_epc_o),
    .config_o(d4_config_o), .prid_o(d4_prid_o), .timer_int_o(d4_timer_int_o),
    .int_pending_o(d4_int_pending_o)
  );

  typedef struct {
    logic [4:0]  waddr;
    logic [4:0]  raddr;
    logic [31:0] wdata;
    logic [31:0] exp_fwd;
    logic [31:0] exp_after;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    tick();
    we_i = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{5'd11, 5'd11, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234};
    vecs[1] = '{5'd14, 5'd14, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{5'd12, 5'd11, 32'h0000_FF00, 32'h0000_1234, 32'h0000_1234};
    vecs[3] = '{5'd13, 5'd13, 32'hFFFF_FFFF, 32'h00C0_0300, 32'h00C0_0300};
    vecs[4] = '{5'd15, 5'd15, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{5'd16, 5'd16, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_8000};
    vecs[6] = '{5'd5,  5'd5,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{5'd9,  5'd9,  32'd100,       32'd100,       32'd100};
    vecs[8] = '{5'd12, 5'd12, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    rst = 1'b0; we_i = 1'b0; waddr_i = '0; raddr_i = 5'd16; data_i = '0; int_i = '0;
    excp_valid_i = 1'b0; excp_code_i = '0; excp_pc_i = '0; excp_in_delay_i = 1'b0; eret_i = 1'b0;

    // Reset state
    #2;
    check("rst_count",   count_o, 32'd0);
    check("rst_d4count", d4_count_o, 32'd0);
    check("rst_config",  d4_config_o, 32'h0000_8000);
    check("rst_data_o",  data_o, 32'd0);
    check("rst_timer",   {31'd0, timer_int_o}, 32'd0);
    tick();
    rst = 1'b1;

    // Prescaler: COUNT_DIV=4 gives 1 after 4 clocks and 3 after 12
    repeat (4) tick();
    check("div4_count4", d4_count_o, 32'd1);
    repeat (8) tick();
    check("div4_count12", d4_count_o, 32'd3);
    check("div1_count12", count_o, 32'd12);

    // Table: MTC0 with forwarded read, then registered readback
    for (int i = 0; i < 9; i++) begin
      we_i = 1'b1; waddr_i = vecs[i].waddr; raddr_i = vecs[i].raddr; data_i = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_fwd", i), data_o, vecs[i].exp_fwd);
      tick();
      we_i = 1'b0;
      #1;
      check($sformatf("vec%0d_after", i), data_o, vecs[i].exp_after);
    end
    tick();
    check("count_after_load", count_o, 32'd102);

    // Timer: Compare=10, Status=IE|IM7, Count=0
    mtc0(5'd11, 32'd10);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd0);
    repeat (10) tick();
    check("tmr_count10", count_o, 32'd10);
    check("tmr_not_yet", {31'd0, timer_int_o}, 32'd0);
    tick();
    check("tmr_set",     {31'd0, timer_int_o}, 32'd1);
    check("tmr_ip7",     {31'd0, cause_o[15]}, 32'd1);
    check("tmr_pending", {31'd0, int_pending_o}, 32'd1);
    tick();
    check("tmr_sticky",  {31'd0, timer_int_o}, 32'd1);

    // Exception in delay slot
    excp_valid_i = 1'b1; excp_code_i = 5'd0; excp_pc_i = 32'h100; excp_in_delay_i = 1'b1;
    tick();
    excp_valid_i = 1'b0;
    check("exc_epc",     epc_o, 32'h0000_00FC);
    check("exc_bd",      {31'd0, cause_o[31]}, 32'd1);
    check("exc_exl",     {31'd0, status_o[1]}, 32'd1);
    check("exc_pending", {31'd0, int_pending_o}, 32'd0);

    // Nested exception leaves EPC/BD alone
    excp_valid_i = 1'b1; excp_code_i = 5'd8; excp_pc_i = 32'h200; excp_in_delay_i = 1'b0;
    tick();
    excp_valid_i = 1'b0;
    check("nest_epc",  epc_o, 32'h0000_00FC);
    check("nest_code", {27'd0, cause_o[6:2]}, 32'd8);
    check("nest_bd",   {31'd0, cause_o[31]}, 32'd1);

    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    check("eret_exl",     {31'd0, status_o[1]}, 32'd0);
    check("eret_pending", {31'd0, int_pending_o}, 32'd1);

    // Compare write clears the timer
    mtc0(5'd11, 32'd50);
    check("cmp_clr_timer", {31'd0, timer_int_o}, 32'd0);
    check("cmp_clr_ip7",   {31'd0, cause_o[15]}, 32'd0);

    // Exception beats a same-cycle MTC0 to EPC, and the read is not forwarded
    excp_valid_i = 1'b1; excp_code_i = 5'd4; excp_pc_i = 32'h300; excp_in_delay_i = 1'b0;
    we_i = 1'b1; waddr_i = 5'd14; raddr_i = 5'd14; data_i = 32'h0000_AAAA;
    #1;
    check("prio_nofwd", data_o, 32'h0000_00FC);
    tick();
    excp_valid_i = 1'b0; we_i = 1'b0;
    check("prio_epc", epc_o, 32'h0000_0300);
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;

    // Hardware interrupt sampling into IP2
    int_i = 6'b000001;
    tick();
    check("int_ip2", {31'd0, cause_o[10]}, 32'd1);
    int_i = 6'b100000;
    tick();
    check("int_ip7", {24'd0, cause_o[15:8]}, 32'h0000_0083);
    int_i = '0;

    // Async reset with timer set
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (6) tick();
    check("pre_rst_timer", {31'd0, timer_int_o}, 32'd1);
    raddr_i = 5'd9;
    rst = 1'b0;
    #1;
    check("arst_count",   count_o, 32'd0);
    check("arst_compare", compare_o, 32'd0);
    check("arst_status",  status_o, 32'd0);
    check("arst_cause",   cause_o, 32'd0);
    check("arst_epc",     epc_o, 32'd0);
    check("arst_timer",   {31'd0, timer_int_o}, 32'd0);
    check("arst_data_o",  data_o, 32'd0);
    check("arst_config",  config_o, 32'h0000_8000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
